ls_multiple_seq: RTL

Sequencer for load/store-multiple instructions (lmw/stmw) in the load/store pipeline. It accepts one decoded multiple-word op from decode, stalls the frontend, and issues one word request per register from rt to 31 with incrementing addresses. It tracks outstanding load responses and steers them to GPR writeback. On completion it pulses done and releases the stall.

---
 rtl/ls_multiple_seq.sv | 134 +++++++++++++
 1 files changed

// File: rtl/ls_multiple_seq.sv
// rtl/ls_multiple_seq.sv - load/store-multiple (lmw/stmw) word request sequencer
// Issues one word request per register rt..NUM_REGS-1 and steers in-order load returns to writeback.
module ls_multiple_seq #(
    parameter int ADDR_WIDTH      = 32,
    parameter int NUM_REGS        = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  is_store,
    input  logic [4:0]            rt,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  stall,
    output logic                  busy,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic                  req_we,
    output logic [ADDR_WIDTH-1:0] req_addr,
    output logic [4:0]            req_reg,
    output logic                  first_cycle,
    output logic                  last,
    input  logic                  resp_valid,
    output logic                  wb_en,
    output logic [4:0]            wb_reg,
    output logic                  done
);
    localparam int              CW       = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [4:0]      LAST_REG = 5'(NUM_REGS - 1);
    localparam logic [CW-1:0]   MAX_CNT  = CW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                  state;
    logic                    store_r;
    logic [4:0]              cur_reg;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [4:0]              wb_reg_r;
    logic [CW-1:0]           outstanding;
    logic [CW-1:0]           cnt_next;
    logic                    first_r;
    logic                    busy_r;
    logic                    done_r;
    logic                    in_issue;
    logic                    is_last;
    logic                    hs;
    logic                    load_hs;

    assign in_issue    = (state == ISSUE);
    assign is_last     = (cur_reg == LAST_REG);
    // Loads throttle on the outstanding limit; stores never wait for responses.
    assign req_valid   = in_issue & (store_r | (outstanding != MAX_CNT));
    assign req_we      = in_issue & store_r;
    assign first_cycle = in_issue & first_r;
    assign last        = in_issue & is_last;
    assign req_addr    = addr;
    assign req_reg     = cur_reg;
    assign wb_reg      = wb_reg_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign stall       = start | (state != IDLE);
    assign wb_en       = resp_valid & ~store_r & (state != IDLE) & (outstanding != '0);

    assign hs      = req_valid & req_ready;
    assign load_hs = hs & ~store_r;

    always_comb begin
        cnt_next = outstanding;
        if (load_hs && !wb_en) begin
            cnt_next = outstanding + CW'(1);
        end else if (!load_hs && wb_en) begin
            cnt_next = outstanding - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            store_r     <= 1'b0;
            cur_reg     <= '0;
            addr        <= '0;
            wb_reg_r    <= '0;
            outstanding <= '0;
            first_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            done_r      <= 1'b0;
            outstanding <= cnt_next;
            if (wb_en) begin
                wb_reg_r <= wb_reg_r + 5'd1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        store_r  <= is_store;
                        cur_reg  <= rt;
                        wb_reg_r <= rt;
                        addr     <= base_addr & ~ADDR_WIDTH'(3);
                        first_r  <= 1'b1;
                        busy_r   <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (hs) begin
                        first_r <= 1'b0;
                        addr    <= addr + ADDR_WIDTH'(4);
                        // cur_reg parks on the last register rather than wrapping.
                        if (is_last) begin
                            if (store_r || cnt_next == '0) begin
                                state  <= IDLE;
                                busy_r <= 1'b0;
                                done_r <= 1'b1;
                            end else begin
                                state <= DRAIN;
                            end
                        end else begin
                            cur_reg <= cur_reg + 5'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (wb_en && outstanding == CW'(1)) begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
